// File: rtl/fec_burst_ctrl.sv
// rtl/fec_burst_ctrl.sv - burst sequencer pacing source data, tail and coded-beat counting for the RS+CC FEC chain
// Optional drain watchdog enabled by defining FEC_CTRL_TIMEOUT_EN.
module fec_burst_ctrl #(
  parameter int W       = 1,
  parameter int NB_W    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      mcs,
  input  logic [NB_W-1:0] num_blocks,
  output logic            busy,
  input  logic [W-1:0]    src_bits,
  input  logic            src_valid,
  output logic            src_ready,
  output logic [W-1:0]    fec_in_bits,
  output logic            fec_in_valid,
  input  logic            fec_out_valid,
  output logic            enable_rs,
  output logic [1:0]      cc_rate,
  output logic            block_done,
  output logic            burst_done,
  output logic            err
);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_DATA  = 2'd1;
  localparam logic [1:0]  S_TAIL  = 2'd2;
  localparam logic [1:0]  S_DRAIN = 2'd3;
  localparam logic [10:0] BPB     = 11'(8 / W);

  logic [1:0]      state;
  logic [2:0]      mcs_q;
  logic [NB_W-1:0] blocks_left;
  logic [10:0]     data_cnt, coded_cnt, coded_next, d_beats, k_beats;
  logic [3:0]      tail_cnt;
  logic [6:0]      u_bytes;
  logic [7:0]      c_bytes;
  logic            cfg_rs;
  logic [1:0]      cfg_rate;
  logic            data_last, tail_last, coded_hit, block_end, timeout_hit;

  // Block geometry follows the latched MCS; the FEC config is decoded from the live input at start.
  always_comb begin
    u_bytes = 7'd12;
    c_bytes = 8'd24;
    case (mcs_q)
      3'd1: begin u_bytes = 7'd24;  c_bytes = 8'd48;  end
      3'd2: begin u_bytes = 7'd36;  c_bytes = 8'd48;  end
      3'd3: begin u_bytes = 7'd48;  c_bytes = 8'd96;  end
      3'd4: begin u_bytes = 7'd72;  c_bytes = 8'd96;  end
      3'd5: begin u_bytes = 7'd96;  c_bytes = 8'd144; end
      3'd6: begin u_bytes = 7'd108; c_bytes = 8'd144; end
      default: ;
    endcase
  end

  always_comb begin
    cfg_rs   = (mcs != 3'd0);
    cfg_rate = 2'd0;
    case (mcs)
      3'd2, 3'd4, 3'd6: cfg_rate = 2'd2;
      3'd5:             cfg_rate = 2'd1;
      default: ;
    endcase
  end

  assign d_beats = (11'(u_bytes) - 11'd1) * BPB;
  assign k_beats = 11'(c_bytes) * BPB;

  assign busy         = (state != S_IDLE);
  assign src_ready    = (state == S_DATA);
  assign fec_in_valid = (state == S_TAIL) || (state == S_DATA && src_valid);
  assign fec_in_bits  = (state == S_DATA) ? src_bits : '0;

  // Coded count saturates at K so that the compare below stays exact.
  assign coded_next = coded_cnt + {10'd0, (fec_out_valid && coded_cnt != k_beats)};
  assign coded_hit  = (coded_next == k_beats);
  assign data_last  = (state == S_DATA) && src_valid && (data_cnt == d_beats - 11'd1);
  assign tail_last  = (state == S_TAIL) && (tail_cnt == BPB[3:0] - 4'd1);
  assign block_end  = coded_hit && (tail_last || state == S_DRAIN);

`ifdef FEC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   wd_cnt <= '0;
    else if (state != S_DRAIN || fec_out_valid)  wd_cnt <= '0;
    else                                         wd_cnt <= wd_cnt + TW'(1);
  end

  assign timeout_hit = (state == S_DRAIN) && !fec_out_valid && (wd_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mcs_q       <= '0;
      blocks_left <= '0;
      data_cnt    <= '0;
      tail_cnt    <= '0;
      coded_cnt   <= '0;
      enable_rs   <= 1'b0;
      cc_rate     <= 2'd0;
      block_done  <= 1'b0;
      burst_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      block_done <= 1'b0;
      burst_done <= 1'b0;
      err        <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          if (mcs == 3'd7) begin
            err <= 1'b1;
          end else if (num_blocks == '0) begin
            burst_done <= 1'b1;
          end else begin
            state       <= S_DATA;
            mcs_q       <= mcs;
            blocks_left <= num_blocks;
            enable_rs   <= cfg_rs;
            cc_rate     <= cfg_rate;
            data_cnt    <= '0;
            tail_cnt    <= '0;
            coded_cnt   <= '0;
          end
        end
      end else begin
        coded_cnt <= coded_next;
        if (state == S_DATA && src_valid) data_cnt <= data_cnt + 11'd1;
        if (data_last) begin
          state    <= S_TAIL;
          tail_cnt <= '0;
        end
        if (state == S_TAIL) begin
          tail_cnt <= tail_cnt + 4'd1;
          if (tail_last) state <= S_DRAIN;
        end
        if (block_end) begin
          block_done <= 1'b1;
          data_cnt   <= '0;
          tail_cnt   <= '0;
          coded_cnt  <= '0;
          if (blocks_left == NB_W'(1)) begin
            burst_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            blocks_left <= blocks_left - NB_W'(1);
            state       <= S_DATA;
          end
        end else if (timeout_hit) begin
          err   <= 1'b1;
          state <= S_IDLE;
        end
      end
    end
  end
endmodule

// File: doc/fec_burst_ctrl.md
Name: fec_burst_ctrl

Overview:
Burst-level sequencer for the FEC chain (RS then CC), sitting between the randomizer output and the FEC input. At burst start it latches a modulation/coding index (MCS) and a block count, and drives the FEC configuration (enable_rs, cc_rate). Per block it paces source data into the FEC, appends the 0x00 tail byte, then counts coded output beats to detect block and burst completion. One block is in flight at a time.

Parameters:
W, 1, bits per beat on all data buses; legal values 1, 2, 4, 8 (8 % W == 0).
NB_W, 8, width of num_blocks.
TIMEOUT, 1024, drain watchdog limit in cycles; used only with FEC_CTRL_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
start  in  1  one-cycle burst start pulse; honoured only in IDLE.
mcs  in  3  MCS index, sampled with start.
num_blocks  in  NB_W  blocks in burst, sampled with start.
busy  out  1  high in any state except IDLE.
src_bits  in  W  source data beat.
src_valid  in  1  source beat valid.
src_ready  out  1  controller accepts a source beat this cycle.
fec_in_bits  out  W  data beat to FEC.
fec_in_valid  out  1  FEC input strobe.
fec_out_valid  in  1  FEC coded-output strobe, counted only.
enable_rs  out  1  RS enable to FEC.
cc_rate  out  2  CC rate to FEC: 0=1/2, 1=2/3, 2=3/4.
block_done  out  1  one-cycle pulse when a block's coded output is complete.
burst_done  out  1  one-cycle pulse when the burst ends.
err  out  1  one-cycle pulse on invalid MCS or watchdog expiry.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, enable_rs 0, cc_rate 0.
- MCS table (uncoded bytes U, coded bytes C, enable_rs, cc_rate):
  - 0: BPSK 1/2: 12, 24, rs 0, rate 0
  - 1: QPSK 1/2: 24, 48, rs 1, rate 0
  - 2: QPSK 3/4: 36, 48, rs 1, rate 2
  - 3: 16QAM 1/2: 48, 96, rs 1, rate 0
  - 4: 16QAM 3/4: 72, 96, rs 1, rate 2
  - 5: 64QAM 2/3: 96, 144, rs 1, rate 1
  - 6: 64QAM 3/4: 108, 144, rs 1, rate 2
  - 7: invalid.
- Per block:
  - data beats D = (U-1)*8/W
  - tail beats T = 8/W
  - coded beats K = C*8/W
  - Counters are sized for the maxima: 856 data beats and 1152 coded beats at W=1.
- enable_rs and cc_rate are registered at start and held constant until the next accepted start.
- States:
  - IDLE: start with mcs 7 -> err pulse next cycle, stay IDLE. start with num_blocks 0 -> burst_done pulse next cycle, stay IDLE. Otherwise latch config and go to DATA.
  - DATA: src_ready=1. fec_in_valid = src_valid & src_ready, and fec_in_bits = src_bits combinationally (zero latency). After the D-th accepted beat, go to TAIL.
  - TAIL: src_ready=0. Drive fec_in_valid=1 with fec_in_bits=0 for T cycles, then go to DRAIN.
  - DRAIN: src_ready=0, fec_in_valid=0. Count fec_out_valid beats from the block's first beat (counting runs in DATA, TAIL and DRAIN). When the count reaches K:
    - block_done pulses.
    - If blocks remain, go to DATA and clear the counters.
    - Otherwise burst_done pulses in the same cycle and the state goes to IDLE.
- Both fec_out_valid and the K-th beat may land in the same cycle as the last tail beat; the block still completes correctly.
- fec_out_valid beats seen in IDLE are ignored.
- start while busy is ignored.
- reset mid-burst aborts immediately to the reset state. No done pulse is issued.
- busy drops in the same cycle burst_done is registered high.

Optional Feature:
FEC_CTRL_TIMEOUT_EN:
- Defined: a cycle counter in DRAIN clears on every fec_out_valid. On reaching TIMEOUT, err pulses, the burst aborts to IDLE, and no block_done or burst_done is issued.
- Undefined: DRAIN waits indefinitely; err is driven only by an invalid MCS.

Test Plan:
- W=1, mcs=1, num_blocks=1, src_valid held 1 -> 184 data beats passed through, then 8 zero tail beats; enable_rs=1, cc_rate=0; after 384 fec_out_valid beats, block_done and burst_done pulse together, busy->0.
- W=8, mcs=6, num_blocks=3 -> per block 107 data beats + 1 zero beat; 144 coded beats each; block_done pulses 3 times, burst_done once; cc_rate=2 throughout.
- mcs=7 start -> err pulse one cycle later, busy stays 0. num_blocks=0 -> burst_done pulse, busy stays 0.
- W=1, mcs=0, src_valid toggling 1/0 -> src_ready high throughout DATA; exactly 88 fec_in_valid beats before the tail; enable_rs=0.
- Second start during a W=1 mcs=2 burst -> ignored, config unchanged. Reset asserted in TAIL -> all outputs 0, state IDLE, no done pulse.
- With FEC_CTRL_TIMEOUT_EN, TIMEOUT=16, fec_out_valid never asserted -> err pulse 16 cycles into DRAIN, return to IDLE.
